btn_cond: RTL and testbench
===========================

BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of consecutive stable cycles required to accept a level change (at least 1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, meaning the cycles from the first pulse to the first auto-repeat pulse (at least 2).
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000, meaning the cycles between subsequent auto-repeat pulses (at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port btn_left_raw, input, 1 bit: asynchronous, bouncing left pushbutton, active-high.
REQ-007 SHALL have port btn_right_raw, input, 1 bit: asynchronous, bouncing right pushbutton, active-high.
REQ-008 SHALL have port left, output, 1 bit: one-cycle move-left pulse, driving the stack stage's left input.
REQ-009 SHALL have port right, output, 1 bit: one-cycle move-right pulse, driving the stack stage's right input.
REQ-010 SHALL have port left_lvl, output, 1 bit: debounced left level.
REQ-011 SHALL have port right_lvl, output, 1 bit: debounced right level.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer before any other logic uses it.
REQ-013 SHALL, per channel, change the debounced level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the counter.
REQ-014 SHALL run a per-channel pulse FSM with states IDLE, DELAY and REPEAT.
REQ-015 IDLE SHALL go to DELAY on a debounced rise, asserting the pulse in the cycle after the level rises.
REQ-016 DELAY SHALL count REPEAT_DELAY cycles from the first pulse; on expiry it SHALL emit a pulse and go to REPEAT.
REQ-017 REPEAT SHALL emit a pulse every REPEAT_RATE cycles.
REQ-018 A debounced fall in any state SHALL go to IDLE immediately, clearing the counter with no further pulse.
REQ-019 Pulses SHALL be exactly one cycle wide, and left and right SHALL never be high in the same cycle.
REQ-020 When both debounced levels are high, both FSMs SHALL be forced to IDLE with no pulses, and SHALL remain suppressed until both levels are low again.
REQ-021 With DEBOUNCE_CYCLES=4, the first pulse SHALL appear exactly 7 cycles after the first clk edge sampling the raw input high: 2 sync + 4 stable + 1 register.
REQ-022 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-023 While rst=0 at a clk edge, all synchronizer flops, counters, levels and outputs SHALL go to 0 and both FSMs to IDLE.
REQ-024 A button held through reset release SHALL be treated as a fresh press: debounced normally, then one pulse.
REQ-025 Reset asserted mid-DELAY or mid-REPEAT SHALL suppress any pending pulse.

Configuration
REQ-026 Macro BTN_COND_AUTOREPEAT_EN, when defined, SHALL enable the DELAY/REPEAT behaviour of REQ-016 and REQ-017.
REQ-027 Without the macro, the FSM SHALL leave IDLE for a HELD state after the first pulse, emit nothing further until release, and REPEAT_DELAY and REPEAT_RATE SHALL be unused.

Structure
REQ-028 Package btn_cond_pkg SHALL hold the FSM state enum (IDLE, DELAY, REPEAT, HELD), the default parameter constants and the synchronizer depth constant (2).
REQ-029 A sub-module btn_debounce (synchronizer plus stability counter) SHALL be instantiated once per channel.
REQ-030 The pulse FSMs and the conflict-suppression logic SHALL reside in btn_cond.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-031 Left raw high for 50 cycles, auto-repeat enabled -> pulses at cycles 7, 27, 35, 43; left_lvl rises at cycle 6; right stays 0.
REQ-032 Right raw toggling every 2 cycles for 30 cycles, then steady high -> no pulse during the bounce; one pulse 7 cycles after the last edge.
REQ-033 Left held, then right pressed at cycle 15 -> no pulses on either output after both levels are high; the first pulse is accepted only after both are released and one is re-pressed.
REQ-034 rst=0 at cycle 24 during left DELAY -> left=0 at cycle 27; after rst=1 with left still held, a pulse arrives 7 cycles later.
REQ-035 Build without BTN_COND_AUTOREPEAT_EN, left held 100 cycles -> exactly one pulse, at cycle 7.
REQ-036 Raw high for only 3 cycles -> left_lvl stays 0 and no pulse is emitted.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg
// Shared definitions for the pushbutton conditioner.
//   - state_t          : per-channel pulse FSM state
//   - DEF_*            : default parameter values for btn_cond
//   - SYNC_DEPTH       : number of synchronizer flops per raw input
//   - cnt_width()      : counter width for a terminal count (never below 1 bit)
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_RATE     = 5000000;
  localparam int SYNC_DEPTH          = 2;

  // A counter that runs 0..p-1 needs $clog2(p) bits; p=1 would give zero bits.
  function automatic int cnt_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One button channel: 2-flop synchronizer followed by a stability counter.
// The debounced level only changes after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   raw  - asynchronous bouncing button input, active-high
//   lvl  - debounced level
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync;
  logic [CW-1:0]         cnt;

  // The counter holds the number of disagreeing samples seen so far; the
  // level flips on the DEBOUNCE_CYCLES-th one, so the count never exceeds
  // CNT_LAST and cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      cnt  <= '0;
      lvl  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], raw};
      if (sync[SYNC_DEPTH-1] == lvl) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        lvl <= sync[SYNC_DEPTH-1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cond.sv
// btn_cond
// Conditions two bouncing pushbuttons into debounced levels and one-cycle
// move pulses. Each channel pulses once on press; with auto-repeat built in
// it pulses again after REPEAT_DELAY cycles and then every REPEAT_RATE
// cycles while held. Pressing both buttons suppresses all pulses until both
// are released.
// Build option: define BTN_COND_AUTOREPEAT_EN to enable auto-repeat;
// otherwise a held button gives exactly one pulse.
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-low reset
//   btn_left_raw  - asynchronous bouncing left button, active-high
//   btn_right_raw - asynchronous bouncing right button, active-high
//   left          - one-cycle move-left pulse
//   right         - one-cycle move-right pulse
//   left_lvl      - debounced left level
//   right_lvl     - debounced right level
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  output logic left,
  output logic right,
  output logic left_lvl,
  output logic right_lvl
);

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam int CW = (cnt_width(REPEAT_DELAY) > cnt_width(REPEAT_RATE)) ?
                      cnt_width(REPEAT_DELAY) : cnt_width(REPEAT_RATE);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_RATE[0];
`endif

  logic [1:0] lvl;
  logic [1:0] pulse;
  logic       conflict;
  logic       supp;
  logic       block;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk (clk),
    .rst (rst),
    .raw (btn_left_raw),
    .lvl (left_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk (clk),
    .rst (rst),
    .raw (btn_right_raw),
    .lvl (right_lvl)
  );

  assign lvl      = {right_lvl, left_lvl};
  assign conflict = left_lvl & right_lvl;
  assign block    = conflict | supp;
  assign left     = pulse[0];
  assign right    = pulse[1];

  // Once both levels have been high together, keep the FSMs parked until
  // both buttons are fully released, so releasing one of the two does not
  // fire a pulse for the other.
  always_ff @(posedge clk) begin
    if (!rst) begin
      supp <= 1'b0;
    end else if (conflict) begin
      supp <= 1'b1;
    end else if (!left_lvl && !right_lvl) begin
      supp <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t state;
    logic   pulse_q;

`ifdef BTN_COND_AUTOREPEAT_EN
    logic [CW-1:0] cnt;
`endif

    assign pulse[ch] = pulse_q;

    // Pulse FSM. A low level or a suppression returns to IDLE in the same
    // edge without a pulse. IDLE with the level high only happens right
    // after a debounced rise, since every path back to IDLE needs the level
    // low (release, reset) or both levels low (suppression).
    always_ff @(posedge clk) begin
      if (!rst || !lvl[ch] || block) begin
        state   <= IDLE;
        pulse_q <= 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
        cnt     <= '0;
`endif
      end else begin
        pulse_q <= 1'b0;
        case (state)
          IDLE: begin
            pulse_q <= 1'b1;
`ifdef BTN_COND_AUTOREPEAT_EN
            state   <= DELAY;
            cnt     <= '0;
`else
            state   <= HELD;
`endif
          end
`ifdef BTN_COND_AUTOREPEAT_EN
          DELAY: begin
            if (cnt >= DELAY_LAST) begin
              pulse_q <= 1'b1;
              state   <= REPEAT;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (cnt >= RATE_LAST) begin
              pulse_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`else
          HELD: begin
            state <= HELD;
          end
`endif
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond
// Self-checking bench for btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Directed scenarios check the documented pulse timings;
// a randomized phase compares every cycle against a behavioural model.
// Honours BTN_COND_AUTOREPEAT_EN the same way the design does.
module tb_btn_cond;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int HMAX = 8192;

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_left_raw = 1'b0;
  logic btn_right_raw = 1'b0;
  logic left, right, left_lvl, right_lvl;

  int checks = 0;
  int errors = 0;
  int gcyc = 0;

  // Behavioural model state
  bit raw_hist [2][HMAX];
  int nsr = 0;
  bit m_lvl [2];
  bit m_pulse [2];
  int start [2];
  bit m_supp = 1'b0;

  btn_cond #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_left_raw  (btn_left_raw),
    .btn_right_raw (btn_right_raw),
    .left          (left),
    .right         (right),
    .left_lvl      (left_lvl),
    .right_lvl     (right_lvl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, gcyc, act, exp);
    end
  endtask

  // Synchronized sample seen by the stability logic at post-reset edge k:
  // the first two edges after reset still see the cleared synchronizer.
  function automatic bit xval(input int ch, input int k);
    if (k >= 3 && (k - 3) < HMAX) return raw_hist[ch][k-3];
    return 1'b0;
  endfunction

  task automatic modelStep(input bit l_raw, input bit r_raw, input bit rs);
    bit raw_in [2];
    bit blocked;
    bit flip;
    int d;
    raw_in[0] = l_raw;
    raw_in[1] = r_raw;
    if (!rs) begin
      nsr = 0;
      m_supp = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_lvl[ch] = 1'b0;
        m_pulse[ch] = 1'b0;
        start[ch] = -1;
      end
      return;
    end
    blocked = (m_lvl[0] && m_lvl[1]) || m_supp;
    for (int ch = 0; ch < 2; ch++) begin
      if (!m_lvl[ch] || blocked) begin
        start[ch] = -1;
        m_pulse[ch] = 1'b0;
      end else if (start[ch] < 0) begin
        start[ch] = gcyc;
        m_pulse[ch] = 1'b1;
      end else begin
        d = gcyc - start[ch];
        m_pulse[ch] = AUTO && (d >= RD) && (((d - RD) % RR) == 0);
      end
    end
    if (m_lvl[0] && m_lvl[1]) m_supp = 1'b1;
    else if (!m_lvl[0] && !m_lvl[1]) m_supp = 1'b0;
    nsr++;
    for (int ch = 0; ch < 2; ch++) begin
      if (nsr <= HMAX) raw_hist[ch][nsr-1] = raw_in[ch];
      if (nsr >= DC) begin
        flip = 1'b1;
        for (int j = 0; j < DC; j++)
          if (xval(ch, nsr - j) == m_lvl[ch]) flip = 1'b0;
        if (flip) m_lvl[ch] = ~m_lvl[ch];
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, step the model on the
  // rising edge, compare shortly after it.
  task automatic applyStimulus(input bit l_raw, input bit r_raw, input bit rs);
    @(negedge clk);
    btn_left_raw = l_raw;
    btn_right_raw = r_raw;
    rst = rs;
    @(posedge clk);
    gcyc++;
    modelStep(l_raw, r_raw, rs);
    #1;
    checkOutput("left", left, m_pulse[0]);
    checkOutput("right", right, m_pulse[1]);
    checkOutput("left_lvl", left_lvl, m_lvl[0]);
    checkOutput("right_lvl", right_lvl, m_lvl[1]);
    checkOutput("exclusive", left & right, 0);
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_outputs", {28'd0, left, right, left_lvl, right_lvl}, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n_l, n_r, n_lv;
    bit rb;
    bit base_l, base_r, bounce, rs;
    int dur;

    start[0] = -1;
    start[1] = -1;
    $display("[TB] starting, AUTO=%0d", AUTO);

    // Single press held 50 cycles
    doReset();
    n_l = 0; n_r = 0;
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (i == 5) checkOutput("lvl_before_c6", left_lvl, 0);
      if (i == 6) checkOutput("lvl_rise_c6", left_lvl, 1);
      if (i == 6) checkOutput("no_pulse_c6", left, 0);
      if (i == 7) checkOutput("first_pulse_c7", left, 1);
      if (i == 8) checkOutput("pulse_width_c8", left, 0);
      if (i == 27) checkOutput("repeat_c27", left, 32'(AUTO));
      if (i == 35) checkOutput("repeat_c35", left, 32'(AUTO));
      if (i == 43) checkOutput("repeat_c43", left, 32'(AUTO));
      n_l += int'(left);
      n_r += int'(right);
    end
    checkOutput("pulse_count_50", n_l, AUTO ? 4 : 1);
    checkOutput("right_quiet", n_r, 0);
    idle(20);

    // Short glitch of 3 cycles
    n_l = 0; n_lv = 0;
    for (int i = 1; i <= 23; i++) begin
      applyStimulus(i <= 3, 1'b0, 1'b1);
      n_l += int'(left);
      n_lv += int'(left_lvl);
    end
    checkOutput("glitch_lvl", n_lv, 0);
    checkOutput("glitch_pulse", n_l, 0);

    // Bouncing right button, then steady high
    n_r = 0;
    for (int i = 1; i <= 45; i++) begin
      rb = (i <= 30) ? bit'(((i - 1) >> 1) & 1) : 1'b1;
      applyStimulus(1'b0, rb, 1'b1);
      if (i <= 36) n_r += int'(right);
      if (i == 37) checkOutput("bounce_pulse_c37", right, 1);
    end
    checkOutput("bounce_quiet", n_r, 0);
    idle(20);

    // Left held, right joins at cycle 15
    n_l = 0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b1, i >= 15, 1'b1);
      if (i == 7) checkOutput("conf_first_c7", left, 1);
      if (i == 20) checkOutput("both_lvl_c20", {30'd0, left_lvl, right_lvl}, 3);
      if (i >= 21) n_l += int'(left) + int'(right);
    end
    checkOutput("both_suppressed", n_l, 0);
    n_l = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      n_l += int'(left) + int'(right);
    end
    checkOutput("one_release_suppressed", n_l, 0);
    idle(15);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      if (i == 7) checkOutput("repress_pulse_c7", right, 1);
    end
    idle(20);

    // Reset during the repeat delay with the button still held
    n_l = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 1'b0, !(i == 24 || i == 25));
      if (i == 24) checkOutput("rst_clears_lvl", left_lvl, 0);
      if (i == 27) checkOutput("rst_kills_c27", left, 0);
      if (i >= 26 && i <= 31) n_l += int'(left);
      if (i == 32) checkOutput("post_rst_pulse", left, 1);
    end
    checkOutput("post_rst_quiet", n_l, 0);
    idle(20);

    // Long hold of 100 cycles
    n_l = 0;
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n_l += int'(left);
    end
    checkOutput("pulse_count_100", n_l, AUTO ? 11 : 1);
    idle(20);

    // Randomized phase: held segments with optional bounce and rare resets
    doReset();
    base_l = 1'b0;
    base_r = 1'b0;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 2) == 0) base_l = ~base_l;
      if ($urandom_range(0, 2) == 0) base_r = ~base_r;
      bounce = ($urandom_range(0, 3) == 0);
      dur = $urandom_range(2, 45);
      rs = ($urandom_range(0, 29) != 0);
      for (int c = 0; c < dur; c++) begin
        applyStimulus(base_l ^ (bounce && $urandom_range(0, 2) == 0),
                      base_r ^ (bounce && $urandom_range(0, 2) == 0),
                      rs || (c > 1));
      end
    end
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
